// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared RV32I load/store definitions
//
// Purpose: funct3 constants, memory addressable-unit modes, LSU state
// encoding and funct3 decode helpers used by the load/store unit.
// Also supplies default widths for `ADDR_WIDTH / `WORD_WIDTH.
// Ports: none (package).

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

package load_store_unit_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic [1:0] BYTE_MEMORY_MODE     = 2'd0;
  localparam logic [1:0] HALFWORD_MEMORY_MODE = 2'd1;
  localparam logic [1:0] WORD_MEMORY_MODE     = 2'd2;

  typedef enum logic [1:0] {
    LSU_IDLE    = 2'd0,
    LSU_ISSUE   = 2'd1,
    LSU_CAPTURE = 2'd2,
    LSU_RESP    = 2'd3
  } lsu_state_t;

  // Low two funct3 bits select the unit; bit 2 only chooses zero-extension.
  function automatic logic [1:0] funct3_to_mode(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return BYTE_MEMORY_MODE;
      2'b01:   return HALFWORD_MEMORY_MODE;
      default: return WORD_MEMORY_MODE;
    endcase
  endfunction

  function automatic logic funct3_illegal(input logic write, input logic [2:0] f3);
    if (write) return (f3 > SW);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/load_store_unit_load_extender.sv
// rtl/load_store_unit_load_extender.sv - load data sign/zero extender
//
// Purpose: purely combinational; turns the raw memory word into the
// architectural load result for the given funct3. Illegal funct3 yields 0.
// Ports:
//   funct3   in   3           load funct3
//   raw      in   WORD_WIDTH  raw memory word (only low bits used for LB/LH)
//   extended out  WORD_WIDTH  extended result

module load_store_unit_load_extender
  import load_store_unit_pkg::*;
#(
  parameter int WORD_WIDTH = `WORD_WIDTH
) (
  input  logic [2:0]            funct3,
  input  logic [WORD_WIDTH-1:0] raw,
  output logic [WORD_WIDTH-1:0] extended
);

  always_comb begin
    extended = '0;
    case (funct3)
      LB:      extended = {{(WORD_WIDTH-8){raw[7]}}, raw[7:0]};
      LH:      extended = {{(WORD_WIDTH-16){raw[15]}}, raw[15:0]};
      LW:      extended = raw;
      LBU:     extended = {{(WORD_WIDTH-8){1'b0}}, raw[7:0]};
      LHU:     extended = {{(WORD_WIDTH-16){1'b0}}, raw[15:0]};
      default: extended = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit in front of a sync byte memory
//
// Purpose: accepts one load/store at a time, checks funct3 (and alignment
// when LSU_MISALIGN_CHECK_EN is defined; otherwise forces the address
// aligned), drives one memory access cycle and returns extended load data
// or a store acknowledge.
// Ports:
//   clk, rst                             clock, sync active-high reset
//   req_valid/req_ready                  request handshake
//   req_write, req_funct3, req_addr, req_wdata   request fields
//   resp_valid/resp_ready                response handshake
//   resp_rdata, resp_err                 response fields
//   mem_read, mem_write, mem_addr_unit, mem_address, mem_wdata  to memory
//   mem_rdata                            from memory, valid cycle after mem_read

module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int WORD_WIDTH = `WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WORD_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WORD_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [1:0]            mem_addr_unit,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic [WORD_WIDTH-1:0] mem_rdata
);

  lsu_state_t state, state_next;

  logic                  write_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WORD_WIDTH-1:0] wdata_q;
  logic [WORD_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic [1:0]            req_mode;
  logic                  req_err;
  logic [ADDR_WIDTH-1:0] req_addr_eff;
  logic [WORD_WIDTH-1:0] ext_rdata;

  // Request decode, evaluated only in the accept cycle.
  always_comb begin
    req_mode     = funct3_to_mode(req_funct3);
    req_addr_eff = req_addr;
`ifdef LSU_MISALIGN_CHECK_EN
    req_err = funct3_illegal(req_write, req_funct3)
            | ((req_mode == HALFWORD_MEMORY_MODE) & req_addr[0])
            | ((req_mode == WORD_MEMORY_MODE) & (|req_addr[1:0]));
`else
    req_err = funct3_illegal(req_write, req_funct3);
    if (req_mode == HALFWORD_MEMORY_MODE) req_addr_eff[0] = 1'b0;
    if (req_mode == WORD_MEMORY_MODE)     req_addr_eff[1:0] = 2'b00;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= LSU_IDLE;
    else     state <= state_next;
  end

  // Memory strobes are gated by ~rst so a reset cycle never writes.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    case (state)
      LSU_IDLE: begin
        req_ready = ~rst;
        if (req_valid) state_next = req_err ? LSU_RESP : LSU_ISSUE;
      end
      LSU_ISSUE: begin
        mem_read   = ~write_q & ~rst;
        mem_write  = write_q & ~rst;
        state_next = write_q ? LSU_RESP : LSU_CAPTURE;
      end
      LSU_CAPTURE: state_next = LSU_RESP;
      LSU_RESP: begin
        resp_valid = ~rst;
        if (resp_ready) state_next = LSU_IDLE;
      end
      default: state_next = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == LSU_IDLE && req_valid) begin
        write_q  <= req_write;
        funct3_q <= req_funct3;
        addr_q   <= req_addr_eff;
        wdata_q  <= req_wdata;
        rdata_q  <= '0;
        err_q    <= req_err;
      end
      if (state == LSU_CAPTURE) rdata_q <= ext_rdata;
    end
  end

  load_store_unit_load_extender #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_load_extender (
    .funct3   (funct3_q),
    .raw      (mem_rdata),
    .extended (ext_rdata)
  );

  assign mem_addr_unit = funct3_to_mode(funct3_q);
  assign mem_address   = addr_q;
  assign mem_wdata     = wdata_q;
  assign resp_rdata    = rdata_q;
  assign resp_err      = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit

module tb_load_store_unit;

  localparam int AW = `ADDR_WIDTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          mem_read;
  logic          mem_write;
  logic [1:0]    mem_addr_unit;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  load_store_unit dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_addr_unit (mem_addr_unit),
    .mem_address   (mem_address),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous byte-addressed memory; reads return four bytes regardless of
  // mode so the LSU must ignore the upper bits itself.
  logic [7:0]    mem [0:(1<<AW)-1];
  logic [AW-1:0] a1, a2, a3;
  assign a1 = mem_address + AW'(1);
  assign a2 = mem_address + AW'(2);
  assign a3 = mem_address + AW'(3);

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_address] <= mem_wdata[7:0];
      if (mem_addr_unit != 2'd0) mem[a1] <= mem_wdata[15:8];
      if (mem_addr_unit == 2'd2) begin
        mem[a2] <= mem_wdata[23:16];
        mem[a3] <= mem_wdata[31:24];
      end
    end
    if (mem_read) mem_rdata <= {mem[a3], mem[a2], mem[a1], mem[mem_address]};
  end

  int wr_cnt = 0;
  int rd_cnt = 0;
  int both_cnt = 0;
  always @(negedge clk) begin
    if (mem_write) wr_cnt++;
    if (mem_read) rd_cnt++;
    if (mem_read && mem_write) both_cnt++;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wr;
    int          rd;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge after the
  // response handshake, with the DUT back in IDLE.
  task automatic do_req(input string tag, input logic w, input logic [2:0] f3,
                        input logic [AW-1:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_lat, input int exp_wr, input int exp_rdc,
                        input int hold);
    exp_t e;
    int cyc;
    int wr0;
    int rd0;
    logic [31:0] held;
    e.rdata = exp_rd; e.err = exp_err; e.lat = exp_lat; e.wr = exp_wr; e.rd = exp_rdc;
    sb.push_back(e);
    check({tag, " req_ready"}, {31'b0, req_ready}, 32'd1);
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (!resp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    e = sb.pop_front();
    check({tag, " latency"}, cyc, e.lat);
    check({tag, " rdata"}, resp_rdata, e.rdata);
    check({tag, " err"}, {31'b0, resp_err}, {31'b0, e.err});
    check({tag, " writes"}, wr_cnt - wr0, e.wr);
    check({tag, " reads"}, rd_cnt - rd0, e.rd);
    held = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold valid"}, {31'b0, resp_valid}, 32'd1);
      check({tag, " hold rdata"}, resp_rdata, held);
      check({tag, " hold ready"}, {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst req_ready", {31'b0, req_ready}, 32'd0);
    check("rst resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst mem strobes", {30'b0, mem_read, mem_write}, 32'd0);
    check("rst resp_rdata", resp_rdata, 32'd0);
    check("rst resp_err", {31'b0, resp_err}, 32'd0);
    check("rst mem_address", {{(32-AW){1'b0}}, mem_address}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_req("SW init10", 1'b1, 3'b010, AW'('h10), 32'h8081F2F3, 32'h0, 1'b0, 2, 1, 0, 0);
    do_req("SW init30", 1'b1, 3'b010, AW'('h30), 32'h11223344, 32'h0, 1'b0, 2, 1, 0, 0);
    do_req("LB 10",  1'b0, 3'b000, AW'('h10), 32'h0, 32'hFFFFFFF3, 1'b0, 3, 0, 1, 0);
    do_req("LBU 11", 1'b0, 3'b100, AW'('h11), 32'h0, 32'h000000F2, 1'b0, 3, 0, 1, 0);
    do_req("LH 12",  1'b0, 3'b001, AW'('h12), 32'h0, 32'hFFFF8081, 1'b0, 3, 0, 1, 0);
    do_req("LHU 12", 1'b0, 3'b101, AW'('h12), 32'h0, 32'h00008081, 1'b0, 3, 0, 1, 0);
    do_req("LW 10",  1'b0, 3'b010, AW'('h10), 32'h0, 32'h8081F2F3, 1'b0, 3, 0, 1, 0);

    do_req("SW 20", 1'b1, 3'b010, AW'('h20), 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 0, 0);
    do_req("SB 21", 1'b1, 3'b000, AW'('h21), 32'h00000055, 32'h0, 1'b0, 2, 1, 0, 0);
    do_req("LW 20", 1'b0, 3'b010, AW'('h20), 32'h0, 32'hDEAD55EF, 1'b0, 3, 0, 1, 0);

`ifdef LSU_MISALIGN_CHECK_EN
    do_req("LW 22 misaligned", 1'b0, 3'b010, AW'('h22), 32'h0, 32'h0, 1'b1, 1, 0, 0, 0);
`else
    do_req("LW 22 forced", 1'b0, 3'b010, AW'('h22), 32'h0, 32'hDEAD55EF, 1'b0, 3, 0, 1, 0);
`endif

    do_req("load f3 011",  1'b0, 3'b011, AW'('h20), 32'h0, 32'h0, 1'b1, 1, 0, 0, 0);
    do_req("store f3 100", 1'b1, 3'b100, AW'('h20), 32'h12345678, 32'h0, 1'b1, 1, 0, 0, 0);

    do_req("LW stall", 1'b0, 3'b010, AW'('h10), 32'h0, 32'h8081F2F3, 1'b0, 3, 0, 1, 5);
    do_req("LBU 13 next", 1'b0, 3'b100, AW'('h13), 32'h0, 32'h00000080, 1'b0, 3, 0, 1, 0);

    // Reset during the ISSUE cycle of a store.
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = AW'('h30); req_wdata = 32'hCAFEBABE;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst issue mem_write", {31'b0, mem_write}, 32'd0);
    @(negedge clk);
    check("post rst strobes", {30'b0, mem_read, mem_write}, 32'd0);
    check("post rst valid/ready", {30'b0, resp_valid, req_ready}, 32'd0);
    check("post rst mem_address", {{(32-AW){1'b0}}, mem_address}, 32'd0);
    check("post rst mem_wdata", mem_wdata, 32'd0);
    check("post rst addr_unit", {30'b0, mem_addr_unit}, 32'd0);
    check("post rst resp", {resp_rdata[30:0], resp_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    do_req("LW 30 old", 1'b0, 3'b010, AW'('h30), 32'h0, 32'h11223344, 1'b0, 3, 0, 1, 0);

    check("read+write overlap", both_cnt, 32'd0);
    check("scoreboard empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
